// File: rtl/patp_sequencer_if.sv
// Handshake and status bundle between the PATP sequencer and its surroundings.
// The master drives the controls, and the sequencer (slave) returns the mode and phase lines.
interface patp_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             step;
  logic             mem_wait;
  logic [2:0]       ir_opcode;
  logic             start_execute;
  logic             start_fetch;
  logic             fault_clr;

  logic             fetch;
  logic             clear;
  logic             inc1;
  logic             add;
  logic             dec1;
  logic             jmp;
  logic             buz;
  logic             load;
  logic             store;
  logic             t1;
  logic             t2;
  logic             t3;
  logic             t4;
  logic             t5;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    output run, step, mem_wait, ir_opcode, start_execute, start_fetch, fault_clr,
    input  fetch, clear, inc1, add, dec1, jmp, buz, load, store,
    input  t1, t2, t3, t4, t5, halted, fault, retired
  );

  modport slave (
    input  run, step, mem_wait, ir_opcode, start_execute, start_fetch, fault_clr,
    output fetch, clear, inc1, add, dec1, jmp, buz, load, store,
    output t1, t2, t3, t4, t5, halted, fault, retired
  );
endinterface

// File: rtl/patp_sequencer.sv
// PATP timing/sequencing controller.
// Produces the fetch/exec mode, the one-hot t1..t5 phases and the decoded instruction lines.
module patp_sequencer #(
  parameter bit          RESET_RUN = 1'b0,
  parameter bit          WATCHDOG  = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  patp_sequencer_if.slave  bus
);

  localparam int unsigned PH_W = 5;
  localparam int unsigned OP_W = 3;
  localparam int unsigned IN_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0]      ST_RST = RESET_RUN ? ST_FETCH : ST_IDLE;
  localparam logic [PH_W-1:0] PH_T1  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_T5  = PH_W'(16);
  localparam logic [PH_W-1:0] PH_RST = RESET_RUN ? PH_T1 : '0;

  logic [1:0]       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Output registers, loaded from the next-state values so they line up with the state.
  logic             fetch_q, fetch_d;
  logic [IN_W-1:0]  instr_q, instr_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      phase_q   <= PH_RST;
      op_q      <= '0;
      step_q    <= 1'b0;
      retired_q <= '0;
      fetch_q   <= RESET_RUN;
      instr_q   <= '0;
      halted_q  <= !RESET_RUN;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      op_q      <= op_d;
      step_q    <= step_d;
      retired_q <= retired_d;
      fetch_q   <= fetch_d;
      instr_q   <= instr_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  // Next state; a mem_wait cycle leaves everything, outputs included, exactly where it was.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    op_d      = op_q;
    step_d    = step_q;
    retired_d = retired_q;

    if (!bus.mem_wait) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.run || bus.step) begin
            state_d = ST_FETCH;
            phase_d = PH_T1;
            step_d  = bus.step;
          end
        end

        ST_FETCH: begin
          if (bus.start_execute) begin
            state_d = ST_EXEC;
            phase_d = PH_T1;
            op_d    = bus.ir_opcode;
          end else if (phase_q == PH_T5) begin
            if (WATCHDOG) begin
              state_d = ST_FAULT;
              phase_d = '0;
            end
          end else begin
            phase_d = {phase_q[PH_W-2:0], 1'b0};
          end
        end

        ST_EXEC: begin
          if (bus.start_fetch) begin
            retired_d = retired_q + CNT_W'(1);
            step_d    = 1'b0;
            if (bus.run && !step_q) begin
              state_d = ST_FETCH;
              phase_d = PH_T1;
            end else begin
              state_d = ST_IDLE;
              phase_d = '0;
            end
          end else if (phase_q == PH_T5) begin
            if (WATCHDOG) begin
              state_d = ST_FAULT;
              phase_d = '0;
              step_d  = 1'b0;
            end
          end else begin
            phase_d = {phase_q[PH_W-2:0], 1'b0};
          end
        end

        default: begin
          if (bus.fault_clr) begin
            state_d = ST_IDLE;
            phase_d = '0;
          end
        end
      endcase
    end
  end

  // Mode, instruction and status lines for the next cycle.
  always_comb begin
    fetch_d  = (state_d == ST_FETCH);
    instr_d  = '0;
    halted_d = (state_d == ST_IDLE) || (state_d == ST_FAULT);
    fault_d  = (state_d == ST_FAULT);
    if (state_d == ST_EXEC) begin
      instr_d = IN_W'(1) << op_d;
    end
  end

  assign bus.fetch   = fetch_q;
  assign bus.clear   = instr_q[0];
  assign bus.inc1    = instr_q[1];
  assign bus.add     = instr_q[2];
  assign bus.dec1    = instr_q[3];
  assign bus.jmp     = instr_q[4];
  assign bus.buz     = instr_q[5];
  assign bus.load    = instr_q[6];
  assign bus.store   = instr_q[7];
  assign bus.t1      = phase_q[0];
  assign bus.t2      = phase_q[1];
  assign bus.t3      = phase_q[2];
  assign bus.t4      = phase_q[3];
  assign bus.t5      = phase_q[4];
  assign bus.halted  = halted_q;
  assign bus.fault   = fault_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_patp_sequencer.sv
// Scoreboard bench for patp_sequencer: two instances, one stopping in IDLE after reset
// with the watchdog on and a 4-bit counter, and one running from reset with the watchdog off.
module tb_patp_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  patp_sequencer_if #(.CNT_W(4))  a ();
  patp_sequencer_if #(.CNT_W(16)) b ();

  patp_sequencer #(.RESET_RUN(1'b0), .WATCHDOG(1'b1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  patp_sequencer #(.RESET_RUN(1'b1), .WATCHDOG(1'b0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] vec;
    int          ret;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_ret = 0;

  localparam int M_NONE  = -1;
  localparam int M_FETCH = 8;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Layout: fetch, clear..store, t1..t5, halted, fault.
  function automatic logic [15:0] ev(input int mode, input int ph, input bit hlt, input bit flt);
    logic [15:0] v;
    v = '0;
    if (mode == M_FETCH) v[15] = 1'b1;
    else if (mode >= 0)  v[14-mode] = 1'b1;
    if (ph >= 1 && ph <= 5) v[7-ph] = 1'b1;
    v[1] = hlt;
    v[0] = flt;
    return v;
  endfunction

  function automatic logic [15:0] obs(input int sel);
    if (sel == 0)
      return {a.fetch, a.clear, a.inc1, a.add, a.dec1, a.jmp, a.buz, a.load, a.store,
              a.t1, a.t2, a.t3, a.t4, a.t5, a.halted, a.fault};
    return {b.fetch, b.clear, b.inc1, b.add, b.dec1, b.jmp, b.buz, b.load, b.store,
            b.t1, b.t2, b.t3, b.t4, b.t5, b.halted, b.fault};
  endfunction

  function automatic logic [31:0] obs_ret(input int sel);
    if (sel == 0) return 32'(a.retired);
    return 32'(b.retired);
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'(1), 32'(0));
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, "_lines"}, 32'(obs(e.sel)), 32'(e.vec));
    check_eq({e.tag, "_ret"}, obs_ret(e.sel), 32'(e.ret));
  endtask

  // Push the expectation, let one clock edge happen, then compare just after it.
  task automatic cyc(input string tag, input int sel, input logic [15:0] v, input int r);
    exp_t e;
    e.tag = tag; e.sel = sel; e.vec = v; e.ret = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic now_chk(input string tag, input int sel, input logic [15:0] v, input int r);
    exp_t e;
    e.tag = tag; e.sel = sel; e.vec = v; e.ret = r;
    sb.push_back(e);
    pop_check();
  endtask

  // From a FETCH phase: start_execute with op, stay len exec phases, then start_fetch.
  task automatic run_instr(input string tag, input int op, input int len, input bit to_fetch);
    a.start_execute = 1'b1;
    a.ir_opcode     = 3'(op);
    cyc({tag, "_e1"}, 0, ev(op, 1, 0, 0), exp_ret);
    a.start_execute = 1'b0;
    for (int p = 2; p <= len; p++) cyc({tag, "_ep"}, 0, ev(op, p, 0, 0), exp_ret);
    a.start_fetch = 1'b1;
    exp_ret = (exp_ret + 1) % 16;
    if (to_fetch) cyc({tag, "_done"}, 0, ev(M_FETCH, 1, 0, 0), exp_ret);
    else          cyc({tag, "_done"}, 0, ev(M_NONE, 0, 1, 0), exp_ret);
    a.start_fetch = 1'b0;
  endtask

  initial begin
    a.run = 0; a.step = 0; a.mem_wait = 0; a.ir_opcode = '0;
    a.start_execute = 0; a.start_fetch = 0; a.fault_clr = 0;
    b.run = 0; b.step = 0; b.mem_wait = 0; b.ir_opcode = '0;
    b.start_execute = 0; b.start_fetch = 0; b.fault_clr = 0;

    repeat (2) @(posedge clk);
    #1;
    now_chk("rst_a", 0, ev(M_NONE, 0, 1, 0), 0);
    now_chk("rst_b", 1, ev(M_FETCH, 1, 0, 0), 0);
    rst_n = 1'b1;

    // Basic fetch, add, return to fetch
    a.run = 1'b1;
    for (int p = 1; p <= 5; p++) cyc("f_ph", 0, ev(M_FETCH, p, 0, 0), 0);
    run_instr("add", 2, 3, 1);

    // Every opcode; jmp/buz finish at t2
    for (int op = 0; op < 8; op++)
      run_instr("dec", op, (op == 4 || op == 5) ? 2 : 3, 1);

    // Seven more to wrap the 4-bit counter
    for (int k = 0; k < 7; k++) run_instr("wrap", 3, 1, 1);
    check_eq("wrap_zero", obs_ret(0), 32'(0));

    // run dropped mid-fetch: the instruction still completes, then IDLE
    a.run = 1'b0;
    cyc("rundrop", 0, ev(M_FETCH, 2, 0, 0), exp_ret);
    run_instr("rundrop", 1, 1, 0);

    // Single step; a second step during EXEC is ignored
    a.step = 1'b1;
    cyc("step_f", 0, ev(M_FETCH, 1, 0, 0), exp_ret);
    a.step = 1'b0;
    a.start_execute = 1'b1; a.ir_opcode = 3'd1;
    cyc("step_e1", 0, ev(1, 1, 0, 0), exp_ret);
    a.start_execute = 1'b0; a.step = 1'b1;
    cyc("step_e2", 0, ev(1, 2, 0, 0), exp_ret);
    a.step = 1'b0; a.start_fetch = 1'b1;
    exp_ret = (exp_ret + 1) % 16;
    cyc("step_end", 0, ev(M_NONE, 0, 1, 0), exp_ret);
    a.start_fetch = 1'b0;
    cyc("step_idle", 0, ev(M_NONE, 0, 1, 0), exp_ret);

    // mem_wait stall at fetch t2, start_execute masked
    a.run = 1'b1;
    cyc("mw_t1", 0, ev(M_FETCH, 1, 0, 0), exp_ret);
    cyc("mw_t2", 0, ev(M_FETCH, 2, 0, 0), exp_ret);
    a.mem_wait = 1'b1; a.start_execute = 1'b1; a.ir_opcode = 3'd7;
    for (int k = 0; k < 3; k++) cyc("mw_hold", 0, ev(M_FETCH, 2, 0, 0), exp_ret);
    a.mem_wait = 1'b0; a.start_execute = 1'b0;
    cyc("mw_t3", 0, ev(M_FETCH, 3, 0, 0), exp_ret);

    // Watchdog: no start_execute at t5
    cyc("wd_t4", 0, ev(M_FETCH, 4, 0, 0), exp_ret);
    cyc("wd_t5", 0, ev(M_FETCH, 5, 0, 0), exp_ret);
    cyc("wd_fault", 0, ev(M_NONE, 0, 1, 1), exp_ret);
    a.step = 1'b1;
    cyc("wd_stay", 0, ev(M_NONE, 0, 1, 1), exp_ret);
    a.step = 1'b0; a.run = 1'b0; a.fault_clr = 1'b1;
    cyc("wd_clr", 0, ev(M_NONE, 0, 1, 0), exp_ret);
    a.fault_clr = 1'b0;
    cyc("wd_idle", 0, ev(M_NONE, 0, 1, 0), exp_ret);

    // Asynchronous reset mid EXEC t2
    a.run = 1'b1;
    cyc("ar_f", 0, ev(M_FETCH, 1, 0, 0), exp_ret);
    a.start_execute = 1'b1; a.ir_opcode = 3'd5;
    cyc("ar_e1", 0, ev(5, 1, 0, 0), exp_ret);
    a.start_execute = 1'b0;
    cyc("ar_e2", 0, ev(5, 2, 0, 0), exp_ret);
    #2;
    rst_n = 1'b0;
    #1;
    exp_ret = 0;
    now_chk("ar_rst_a", 0, ev(M_NONE, 0, 1, 0), 0);
    now_chk("ar_rst_b", 1, ev(M_FETCH, 1, 0, 0), 0);
    a.run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Run-from-reset instance without watchdog: t5 holds
    for (int p = 2; p <= 5; p++) cyc("nowd_ph", 1, ev(M_FETCH, p, 0, 0), 0);
    cyc("nowd_hold", 1, ev(M_FETCH, 5, 0, 0), 0);
    cyc("nowd_hold", 1, ev(M_FETCH, 5, 0, 0), 0);
    now_chk("nowd_a_idle", 0, ev(M_NONE, 0, 1, 0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
